pulse_transmitter_edge_event_unit: RTL and testbench
====================================================

PULSE_TRANSMITTER_EDGE_EVENT_UNIT -- requirements
Module: pulse_transmitter_edge_event_unit

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter FILT_W, default 4: width of the glitch-filter length field and per-channel counter.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 sig_in  input  NUM_CH  raw input level per channel.
REQ-006 mode_i  input  2*NUM_CH  per-channel detect mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
REQ-007 filt_len_i  input  FILT_W  stable-cycle count L required before a level change is accepted; shared by all channels.
REQ-008 clr_i  input  NUM_CH  write-1-to-clear strobe for pending_o.
REQ-009 pulse_out  output  NUM_CH  registered one-cycle event pulse per channel.
REQ-010 pending_o  output  NUM_CH  sticky event flag per channel.
REQ-011 irq_o  output  1  OR-reduction of pending_o, registered-equivalent (no combinational path from sig_in).

Function
REQ-012 Each channel SHALL hold a filtered level filt and a counter cnt (FILT_W bits).
REQ-013 If the sampled input s equals filt, cnt SHALL be cleared to 0.
REQ-014 If s differs from filt and cnt != L, cnt SHALL increment by 1; if cnt == L, filt SHALL take s and cnt SHALL clear.
REQ-015 With L = 0, a change sampled at edge N SHALL update filt at edge N; with L, at edge N+L if s stays different throughout.
REQ-016 A difference lasting fewer than L+1 consecutive samples SHALL produce no filt change and no event.
REQ-017 On a filt update 0->1, pulse_out[c] SHALL be set for exactly one cycle at the same edge if mode is 01 or 11; on 1->0, if mode is 10 or 11.
REQ-018 Mode 00 SHALL suppress events while filt continues tracking the input.
REQ-019 Changes to mode_i or filt_len_i SHALL take effect on the next clock edge with no other side effects; a cnt already above a reduced L SHALL count up to wrap-around at 2^FILT_W and restart.
REQ-020 pending_o[c] SHALL set on the edge pulse_out[c] is set and clear when clr_i[c] is high; simultaneous set and clear SHALL leave pending set.
REQ-021 irq_o SHALL be high iff any pending_o bit is high.

Reset
REQ-022 While rst_n is low: filt, cnt, pulse_out, pending_o, irq_o and any synchroniser flops SHALL be 0.
REQ-023 An input held high through reset SHALL be reported as a rising edge after L+1 samples (plus synchroniser latency) if the channel mode enables rising.
REQ-024 Reset asserted mid-filter SHALL discard the partial count with no event.

Configuration
REQ-025 Macro PULSE_TRANSMITTER_EDGE_SYNC_EN defined: each sig_in bit SHALL pass through a two-flop synchroniser before the filter, adding exactly 2 cycles of latency.
REQ-026 Macro undefined: sig_in SHALL feed the filter directly; inputs are then required to be synchronous to clk.

Structure
REQ-027 Package pulse_transmitter_pkg SHALL hold the mode typedef (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH) and the default NUM_CH and FILT_W constants.
REQ-028 Per-channel logic SHALL be sub-module pulse_transmitter_edge_channel, instantiated NUM_CH times by generate.

Verification
REQ-029 L=0, ch0 mode 10, no sync: sig_in[0] 1->0 sampled at edge N -> pulse_out[0] high for one cycle after edge N, pending_o[0]=1, irq_o=1.
REQ-030 L=3, ch1 mode 01: 3-cycle high glitch -> no pulse; 4-cycle high -> one pulse after the 4th sampling edge.
REQ-031 ch2 mode 11, L=0: toggle sig_in[2] every 5 cycles for 20 cycles -> 4 pulses, each one cycle wide.
REQ-032 clr_i[0]=1 on the same edge that pulse_out[0] sets -> pending_o[0] stays 1; clr_i[0]=1 one cycle later -> pending_o[0]=0, irq_o=0.
REQ-033 sig_in=4'hF held through reset, all modes 01, L=2 -> four pulses 3 cycles after rst_n rises (5 with PULSE_TRANSMITTER_EDGE_SYNC_EN).
REQ-034 Mode 00 on ch3 with edges, then switch to 10 -> no events while off, and only the next falling edge is reported.

Source files
------------

// File: rtl/pulse_transmitter_pkg.sv
// Shared types and defaults for the pulse transmitter edge/event unit.
// Optional build macro: PULSE_TRANSMITTER_EDGE_SYNC_EN (see channel file).
package pulse_transmitter_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   localparam int DEF_NUM_CH = 4;
   localparam int DEF_FILT_W = 4;

   function automatic logic rise_en(input logic [1:0] m);
      edge_mode_e em;
      em = edge_mode_e'(m);
      return (em == EDGE_RISE) || (em == EDGE_BOTH);
   endfunction

   function automatic logic fall_en(input logic [1:0] m);
      edge_mode_e em;
      em = edge_mode_e'(m);
      return (em == EDGE_FALL) || (em == EDGE_BOTH);
   endfunction

endpackage

// File: rtl/pulse_transmitter_edge_event_unit_if.sv
// Signal bundle between the edge/event unit and its controller.
interface pulse_transmitter_edge_event_unit_if #(
   parameter int NUM_CH = 4,
   parameter int FILT_W = 4
);
   logic [NUM_CH-1:0]   sig_in;
   logic [2*NUM_CH-1:0] mode_i;
   logic [FILT_W-1:0]   filt_len_i;
   logic [NUM_CH-1:0]   clr_i;
   logic [NUM_CH-1:0]   pulse_out;
   logic [NUM_CH-1:0]   pending_o;
   logic                irq_o;

   modport master (
      output sig_in, mode_i, filt_len_i, clr_i,
      input  pulse_out, pending_o, irq_o
   );

   modport slave (
      input  sig_in, mode_i, filt_len_i, clr_i,
      output pulse_out, pending_o, irq_o
   );
endinterface

// File: rtl/pulse_transmitter_edge_channel.sv
// One channel: optional two-flop synchroniser, glitch filter, edge event
// pulse and sticky pending flag.
// Macro PULSE_TRANSMITTER_EDGE_SYNC_EN inserts the synchroniser (+2 cycles).
module pulse_transmitter_edge_channel
   import pulse_transmitter_pkg::*;
#(
   parameter int FILT_W = DEF_FILT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sig_raw,
   input  logic [1:0]        mode,
   input  logic [FILT_W-1:0] filt_len,
   input  logic              clr,
   output logic              pulse,
   output logic              pending
);

   logic              s;
   logic              filt_q, filt_d;
   logic [FILT_W-1:0] cnt_q, cnt_d;
   logic              evt;

`ifdef PULSE_TRANSMITTER_EDGE_SYNC_EN
   logic [1:0] sync_q;

   // two-flop synchroniser for the asynchronous input level
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[0], sig_raw};
   end

   assign s = sync_q[1];
`else
   assign s = sig_raw;
`endif

   // filter: accept a new level after it has differed for filt_len+1 samples;
   // a counter left above a lowered filt_len simply wraps and catches up
   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      evt    = 1'b0;
      if (s == filt_q) begin
         cnt_d = '0;
      end else if (cnt_q != filt_len) begin
         cnt_d = cnt_q + FILT_W'(1);
      end else begin
         filt_d = s;
         cnt_d  = '0;
         evt    = s ? rise_en(mode) : fall_en(mode);
      end
   end

   // state, event pulse and sticky flag (a set wins over a same-cycle clear)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt_q  <= 1'b0;
         cnt_q   <= '0;
         pulse   <= 1'b0;
         pending <= 1'b0;
      end else begin
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
         pulse   <= evt;
         pending <= evt | (pending & ~clr);
      end
   end

endmodule

// File: rtl/pulse_transmitter_edge_event_unit.sv
// Multi-channel filtered edge detector with per-channel event pulses,
// sticky pending flags and a combined interrupt.
// Macro PULSE_TRANSMITTER_EDGE_SYNC_EN adds input synchronisers.
module pulse_transmitter_edge_event_unit
   import pulse_transmitter_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int FILT_W = DEF_FILT_W
) (
   input logic clk,
   input logic rst_n,
   pulse_transmitter_edge_event_unit_if.slave bus
);

   logic [NUM_CH-1:0] pulse_v;
   logic [NUM_CH-1:0] pending_v;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      pulse_transmitter_edge_channel #(.FILT_W(FILT_W)) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .sig_raw  (bus.sig_in[c]),
         .mode     (bus.mode_i[2*c+1:2*c]),
         .filt_len (bus.filt_len_i),
         .clr      (bus.clr_i[c]),
         .pulse    (pulse_v[c]),
         .pending  (pending_v[c])
      );
   end

   assign bus.pulse_out = pulse_v;
   assign bus.pending_o = pending_v;
   // pending flags are flops, so the interrupt has no path from sig_in
   assign bus.irq_o     = |pending_v;

endmodule

// File: tb/tb_pulse_transmitter_edge_event_unit.sv
// Directed bench for pulse_transmitter_edge_event_unit.
module tb_pulse_transmitter_edge_event_unit;

`ifdef PULSE_TRANSMITTER_EDGE_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   pulse_transmitter_edge_event_unit_if #(.NUM_CH(4), .FILT_W(4)) bus ();

   pulse_transmitter_edge_event_unit #(.NUM_CH(4), .FILT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic count_pulses(input int n, input int ch, output int highs, output int rises);
      logic prev;
      highs = 0;
      rises = 0;
      prev  = bus.pulse_out[ch];
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.pulse_out[ch]) highs++;
         if (bus.pulse_out[ch] && !prev) rises++;
         prev = bus.pulse_out[ch];
      end
   endtask

   int hi, ri;

   initial begin
      rst_n          = 1'b0;
      bus.sig_in     = 4'h0;
      bus.mode_i     = 8'h00;
      bus.filt_len_i = 4'd0;
      bus.clr_i      = 4'h0;
      tick_n(3);
      chk("rst_pulse", 32'(bus.pulse_out), 32'h0);
      chk("rst_pending", 32'(bus.pending_o), 32'h0);
      chk("rst_irq", 32'(bus.irq_o), 32'h0);

      // L=0, ch0 falling only
      bus.mode_i = 8'b0000_0010;
      rst_n = 1'b1;
      bus.sig_in[0] = 1'b1;
      tick_n(1 + SL);
      chk("rise_masked_pulse", 32'(bus.pulse_out), 32'h0);
      chk("rise_masked_pending", 32'(bus.pending_o), 32'h0);
      bus.sig_in[0] = 1'b0;
      tick_n(SL);
      chk("fall_before_edge", 32'(bus.pulse_out), 32'h0);
      tick();
      chk("fall_pulse", 32'(bus.pulse_out), 32'h1);
      chk("fall_pending", 32'(bus.pending_o), 32'h1);
      chk("fall_irq", 32'(bus.irq_o), 32'h1);
      tick();
      chk("fall_pulse_width", 32'(bus.pulse_out), 32'h0);
      chk("fall_pending_sticky", 32'(bus.pending_o), 32'h1);

      bus.clr_i = 4'h1;
      tick();
      bus.clr_i = 4'h0;
      chk("clr_pending", 32'(bus.pending_o), 32'h0);
      chk("clr_irq", 32'(bus.irq_o), 32'h0);

      // clear coinciding with the set edge
      bus.sig_in[0] = 1'b1;
      tick_n(1 + SL);
      bus.sig_in[0] = 1'b0;
      tick_n(SL);
      bus.clr_i = 4'h1;
      tick();
      bus.clr_i = 4'h0;
      chk("setclr_pulse", 32'(bus.pulse_out), 32'h1);
      chk("setclr_pending", 32'(bus.pending_o), 32'h1);
      bus.clr_i = 4'h1;
      tick();
      bus.clr_i = 4'h0;
      chk("late_clr_pending", 32'(bus.pending_o), 32'h0);
      chk("late_clr_irq", 32'(bus.irq_o), 32'h0);

      // L=3, ch1 rising: 3-cycle glitch rejected, 4-cycle level accepted
      bus.filt_len_i = 4'd3;
      bus.mode_i = 8'b0000_0110;
      bus.sig_in[1] = 1'b1;
      tick_n(3);
      bus.sig_in[1] = 1'b0;
      count_pulses(SL + 6, 1, hi, ri);
      chk("glitch3_pulses", 32'(hi), 32'd0);
      chk("glitch3_pending", 32'(bus.pending_o), 32'h0);
      bus.sig_in[1] = 1'b1;
      tick_n(3 + SL);
      chk("hold4_before", 32'(bus.pulse_out), 32'h0);
      tick();
      chk("hold4_pulse", 32'(bus.pulse_out), 32'h2);
      tick();
      chk("hold4_width", 32'(bus.pulse_out), 32'h0);
      chk("hold4_pending", 32'(bus.pending_o), 32'h2);
      bus.clr_i = 4'hF;
      tick();
      bus.clr_i = 4'h0;

      // L=0, ch2 both edges, toggle every 5 cycles
      bus.filt_len_i = 4'd0;
      bus.mode_i = 8'b0011_0110;
      for (int k = 0; k < 4; k++) begin
         bus.sig_in[2] = ~bus.sig_in[2];
         count_pulses(5, 2, hi, ri);
         chk("toggle_pulse_high_cycles", 32'(hi), 32'd1);
         chk("toggle_pulse_count", 32'(ri), 32'd1);
      end
      bus.clr_i = 4'hF;
      tick();
      bus.clr_i = 4'h0;

      // ch3 off while toggling, then falling only
      bus.mode_i = 8'b0000_0000;
      for (int k = 0; k < 3; k++) begin
         bus.sig_in[3] = ~bus.sig_in[3];
         count_pulses(3 + SL, 3, hi, ri);
         chk("off_no_pulse", 32'(hi), 32'd0);
      end
      chk("off_no_pending", 32'(bus.pending_o), 32'h0);
      bus.mode_i = 8'b1000_0000;
      bus.sig_in[3] = 1'b0;
      count_pulses(3 + SL, 3, hi, ri);
      chk("on_fall_pulse", 32'(hi), 32'd1);
      bus.sig_in[3] = 1'b1;
      count_pulses(3 + SL, 3, hi, ri);
      chk("on_rise_ignored", 32'(hi), 32'd0);
      chk("on_pending", 32'(bus.pending_o), 32'h8);

      // reset mid-filter discards partial count
      bus.filt_len_i = 4'd3;
      bus.mode_i = 8'b1111_1111;
      bus.sig_in = 4'hF;
      bus.sig_in[0] = 1'b1;
      tick_n(2 + SL);
      rst_n = 1'b0;
      tick();
      chk("midrst_pending", 32'(bus.pending_o), 32'h0);
      chk("midrst_irq", 32'(bus.irq_o), 32'h0);
      bus.sig_in = 4'h0;
      rst_n = 1'b1;
      count_pulses(8 + SL, 0, hi, ri);
      chk("midrst_no_pulse", 32'(hi), 32'd0);

      // inputs high through reset, L=2, all rising
      rst_n = 1'b0;
      bus.sig_in = 4'hF;
      bus.mode_i = 8'b0101_0101;
      bus.filt_len_i = 4'd2;
      tick_n(3);
      chk("hold_rst_pulse", 32'(bus.pulse_out), 32'h0);
      rst_n = 1'b1;
      tick_n(2 + SL);
      chk("hold_rst_before", 32'(bus.pulse_out), 32'h0);
      tick();
      chk("hold_rst_pulse_all", 32'(bus.pulse_out), 32'hF);
      chk("hold_rst_pending_all", 32'(bus.pending_o), 32'hF);
      tick();
      chk("hold_rst_width", 32'(bus.pulse_out), 32'h0);
      bus.clr_i = 4'hF;
      tick();
      bus.clr_i = 4'h0;

      // lowering L below a running count: counter wraps before accepting
      bus.filt_len_i = 4'd5;
      bus.mode_i = 8'b0000_0010;
      bus.sig_in[0] = 1'b0;
      tick_n(SL + 4);
      bus.filt_len_i = 4'd2;
      count_pulses(14, 0, hi, ri);
      chk("wrap_no_early_pulse", 32'(hi), 32'd0);
      tick();
      chk("wrap_pulse", 32'(bus.pulse_out), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
